// File: rtl/game_pkg.sv
// Shared definitions for the number-guessing game controller: widths,
// LFSR constants, the state enumeration and two small arithmetic helpers.
package game_pkg;

    localparam int TIME_W = 5;   // width of timer seconds
    localparam int NUM_W  = 8;   // width of target, guess and score

    localparam logic [NUM_W-1:0] LFSR_SEED = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a left-shifting register)
    localparam logic [NUM_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_PLAY = 3'd3,
        ST_HIT  = 3'd4,
        ST_MISS = 3'd5,
        ST_OVER = 3'd6
    } state_e;

    // Round length shrinks by one second per won round down to a floor;
    // the floor is at least 1, so a zero (never-expiring) load cannot occur.
    function automatic logic [TIME_W-1:0] load_time(input logic [NUM_W-1:0] won,
                                                    input int round_time,
                                                    input int min_time);
        int t;
        t = round_time - int'(won);
        if (t < min_time) t = min_time;
        return TIME_W'(t);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] v);
        return (v == '1) ? v : v + NUM_W'(1);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies round targets.
// Starts from a non-zero seed and, being maximal length, never reaches zero.
module game_lfsr
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [NUM_W-1:0] value
);

    // Shift toward the MSB every clock, feeding back the XOR of the tapped bits.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= LFSR_SEED;
        else        value <= {value[NUM_W-2:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/game_ctrl.sv
// Round sequencer for a guess-the-number game: loads the countdown timer,
// picks a target from the LFSR, judges submits against timeouts and keeps
// score and lives until the game ends.
module game_ctrl
    import game_pkg::*;
#(
    parameter int ROUND_TIME = 20,
    parameter int MIN_TIME   = 5,
    parameter int LIVES      = 3,
    parameter int MAX_ROUNDS = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              submit,
    input  logic [NUM_W-1:0]  guess,
    input  logic [TIME_W-1:0] timeleft,
    input  logic              end_f,
    output logic              set_f,
    output logic [TIME_W-1:0] set_v,
    output logic [NUM_W-1:0]  target,
    output logic [NUM_W-1:0]  score,
    output logic [1:0]        lives,
    output logic              round_active,
    output logic              game_over,
    output logic              hit_p,
    output logic              miss_p
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] LOAD = ST_LOAD;
    localparam logic [2:0] ARM  = ST_ARM;
    localparam logic [2:0] PLAY = ST_PLAY;
    localparam logic [2:0] HIT  = ST_HIT;
    localparam logic [2:0] MISS = ST_MISS;
    localparam logic [2:0] OVER = ST_OVER;

    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [NUM_W-1:0] WIN_LIMIT  = NUM_W'(MAX_ROUNDS);

    logic [2:0]       state, state_nx;
    logic [NUM_W-1:0] won, won_nx, score_nx;
    logic [1:0]       lives_nx, lives_dec;
    logic [NUM_W-1:0] won_inc;
    logic [NUM_W-1:0] lfsr_value;
    logic             start_r, start_rr, submit_r, submit_rr;
    logic             start_ev, submit_ev;

    // timeleft only drives the external display; no decision here looks at it.
    logic unused_timeleft;
    assign unused_timeleft = ^timeleft;

    game_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_value)
    );

    // Two register stages per button: the edge is seen only from registered
    // history, so a button already high at reset release needs two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r   <= 1'b0;
            start_rr  <= 1'b0;
            submit_r  <= 1'b0;
            submit_rr <= 1'b0;
        end else begin
            start_r   <= start;
            start_rr  <= start_r;
            submit_r  <= submit;
            submit_rr <= submit_r;
        end
    end

    assign start_ev  = start_r  & ~start_rr;
    assign submit_ev = submit_r & ~submit_rr;
    assign won_inc   = sat_inc(won);
    assign lives_dec = lives - 2'd1;

    // Next state plus the next score/won/lives implied by the transition.
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        won_nx   = won;
        score_nx = score;
        lives_nx = lives;
        unique case (state)
            IDLE, OVER: begin
                if (start_ev) begin
                    state_nx = LOAD;
                    won_nx   = '0;
                    score_nx = '0;
                    lives_nx = LIVES_INIT;
                end
            end
            LOAD: state_nx = ARM;
            // The timer still shows the previous expiry here, so end_f is ignored.
            ARM:  state_nx = PLAY;
            PLAY: begin
                // A timeout beats a simultaneous correct submit.
                if (end_f)                                state_nx = MISS;
                else if (submit_ev && (guess == target))  state_nx = HIT;
            end
            HIT: begin
                won_nx   = won_inc;
                score_nx = sat_inc(score);
                state_nx = (won_inc == WIN_LIMIT) ? OVER : LOAD;
            end
            MISS: begin
                lives_nx = lives_dec;
                state_nx = (lives_dec == 2'd0) ? OVER : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and game registers; set_v and target are captured on entry to
    // LOAD so they are already valid while set_f is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            won    <= '0;
            score  <= '0;
            lives  <= LIVES_INIT;
            set_v  <= '0;
            target <= '0;
        end else begin
            state <= state_nx;
            won   <= won_nx;
            score <= score_nx;
            lives <= lives_nx;
            if (state_nx == LOAD) begin
                set_v  <= load_time(won_nx, ROUND_TIME, MIN_TIME);
                target <= lfsr_value;
            end
        end
    end

    assign set_f        = (state == LOAD);
    assign round_active = (state == PLAY);
    assign game_over    = (state == OVER);
    assign hit_p        = (state == HIT);
    assign miss_p       = (state == MISS);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a rule-level game model compared on
// every falling edge, plus directed scenarios with literal expectations.
module tb_game_ctrl;

    localparam int ROUND_TIME = 20;
    localparam int MIN_TIME   = 5;
    localparam int LIVES      = 3;
    localparam int MAX_ROUNDS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] guess = 8'd0;
    logic [4:0] timeleft = 5'd0;
    logic       end_f = 1'b0;
    logic       set_f;
    logic [4:0] set_v;
    logic [7:0] target;
    logic [7:0] score;
    logic [1:0] lives;
    logic       round_active;
    logic       game_over;
    logic       hit_p;
    logic       miss_p;

    game_ctrl #(
        .ROUND_TIME (ROUND_TIME),
        .MIN_TIME   (MIN_TIME),
        .LIVES      (LIVES),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .submit       (submit),
        .guess        (guess),
        .timeleft     (timeleft),
        .end_f        (end_f),
        .set_f        (set_f),
        .set_v        (set_v),
        .target       (target),
        .score        (score),
        .lives        (lives),
        .round_active (round_active),
        .game_over    (game_over),
        .hit_p        (hit_p),
        .miss_p       (miss_p)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_ARM, M_PLAY, M_HIT, M_MISS, M_OVER} mphase_e;

    mphase_e m_phase  = M_IDLE;
    int      m_score  = 0;
    int      m_won    = 0;
    int      m_lives  = LIVES;
    int      m_set_v  = 0;
    int      m_target = 0;
    int      m_lfsr   = 'hA5;
    bit      s1 = 0, s2 = 0, u1 = 0, u2 = 0;   // button samples from the last two edges

    function automatic int lfsr_step(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 'hFF) | fb;
    endfunction

    function automatic int round_secs(input int won);
        return (ROUND_TIME - won > MIN_TIME) ? ROUND_TIME - won : MIN_TIME;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit st_ev;
        bit sub_ev;
        int pre;
        if (!rst_n) begin
            m_phase = M_IDLE; m_score = 0; m_won = 0; m_lives = LIVES;
            m_set_v = 0; m_target = 0; m_lfsr = 'hA5;
            s1 = 0; s2 = 0; u1 = 0; u2 = 0;
        end else begin
            st_ev  = s1 && !s2;
            sub_ev = u1 && !u2;
            pre    = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            case (m_phase)
                M_IDLE, M_OVER: if (st_ev) begin
                    m_score = 0; m_won = 0; m_lives = LIVES;
                    m_phase = M_LOAD; m_set_v = round_secs(m_won); m_target = pre;
                end
                M_LOAD: m_phase = M_ARM;
                M_ARM:  m_phase = M_PLAY;
                M_PLAY: begin
                    if (end_f)                                   m_phase = M_MISS;
                    else if (sub_ev && int'(guess) == m_target)  m_phase = M_HIT;
                end
                M_HIT: begin
                    if (m_score < 255) m_score++;
                    if (m_won < 255)   m_won++;
                    if (m_won == MAX_ROUNDS) m_phase = M_OVER;
                    else begin m_phase = M_LOAD; m_set_v = round_secs(m_won); m_target = pre; end
                end
                M_MISS: begin
                    m_lives--;
                    if (m_lives == 0) m_phase = M_OVER;
                    else begin m_phase = M_LOAD; m_set_v = round_secs(m_won); m_target = pre; end
                end
                default: m_phase = M_IDLE;
            endcase
            s2 = s1; s1 = start; u2 = u1; u1 = submit;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        check("cyc_set_f",        int'(set_f),        int'(m_phase == M_LOAD));
        check("cyc_set_v",        int'(set_v),        m_set_v);
        check("cyc_target",       int'(target),       m_target);
        check("cyc_score",        int'(score),        m_score);
        check("cyc_lives",        int'(lives),        m_lives);
        check("cyc_round_active", int'(round_active), int'(m_phase == M_PLAY));
        check("cyc_game_over",    int'(game_over),    int'(m_phase == M_OVER));
        check("cyc_hit_p",        int'(hit_p),        int'(m_phase == M_HIT));
        check("cyc_miss_p",       int'(miss_p),       int'(m_phase == M_MISS));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            timeleft = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic wait_play(input string tag);
        int k = 0;
        while (!round_active && k < 40) begin tick(); k++; end
        check({tag, "_reach_play"}, int'(round_active), 1);
    endtask

    task automatic wait_set_f(input string tag);
        int k = 0;
        while (!set_f && k < 40) begin tick(); k++; end
        check({tag, "_reach_load"}, int'(set_f), 1);
    endtask

    // Press submit once (guess already set) and expect a hit; returns in the cycle after HIT.
    task automatic press_hit(input string tag);
        int k = 0;
        submit = 1'b1; tick(); submit = 1'b0;
        while (!hit_p && k < 6) begin tick(); k++; end
        check({tag, "_hit_p"}, int'(hit_p), 1);
        tick();
    endtask

    task automatic win_round();
        wait_play("win");
        guess = target;
        press_hit("win");
    endtask

    task automatic miss_round();
        wait_play("miss");
        end_f = 1'b1; tick(); end_f = 1'b0;
        check("timeout_miss_p", int'(miss_p), 1);
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(3);
        check("rst_set_f",        int'(set_f), 0);
        check("rst_set_v",        int'(set_v), 0);
        check("rst_target",       int'(target), 0);
        check("rst_score",        int'(score), 0);
        check("rst_lives",        int'(lives), 3);
        check("rst_round_active", int'(round_active), 0);
        check("rst_game_over",    int'(game_over), 0);

        // start held across reset release: LOAD on the second edge, not the first
        start = 1'b1; tick(); rst_n = 1'b1;
        tick(); check("start_not_first_edge", int'(set_f), 0);
        tick();
        check("g1_load_set_f",  int'(set_f), 1);
        check("g1_load_set_v",  int'(set_v), 20);
        check("g1_load_target", int'(target), 'h4A);
        check("g1_load_lives",  int'(lives), 3);
        check("g1_load_score",  int'(score), 0);
        tick(); check("set_f_one_cycle", int'(set_f), 0);
        check("arm_not_active", int'(round_active), 0);
        tick(); check("play_two_later", int'(round_active), 1);
        start = 1'b0;

        // winning rounds shorten the timer down to the floor
        win_round();
        check("score_after_1", int'(score), 1);
        check("set_v_after_1", int'(set_v), 19);
        repeat (14) win_round();
        check("score_after_15", int'(score), 15);
        check("set_v_after_15", int'(set_v), 5);
        miss_round();
        check("lives_after_miss", int'(lives), 2);
        check("set_v_floor_held", int'(set_v), 5);
        win_round();
        check("g1_over",     int'(game_over), 1);
        check("g1_score_16", int'(score), 16);
        tick(3);
        check("over_holds_score", int'(score), 16);
        check("over_no_load",     int'(set_f), 0);

        // game 2: restart from OVER, end_f during ARM must be ignored
        start = 1'b1; wait_set_f("g2");
        check("g2_set_v",  int'(set_v), 20);
        check("g2_score",  int'(score), 0);
        check("g2_lives",  int'(lives), 3);
        start = 1'b0;
        tick(); end_f = 1'b1;
        tick(); end_f = 1'b0;
        check("arm_ignores_end_f", int'(round_active), 1);
        tick(2);
        check("arm_end_f_no_miss", int'(lives), 3);

        // held submit: no hit until released and re-pressed
        guess = target ^ 8'h01; submit = 1'b1; tick(4);
        check("wrong_guess_ignored", int'(round_active), 1);
        guess = target; tick(4);
        check("held_submit_no_hit", int'(score), 0);
        check("held_submit_in_play", int'(round_active), 1);
        submit = 1'b0; tick();
        press_hit("repress");
        check("repress_score", int'(score), 1);

        // timeout and correct submit in the same cycle: timeout wins
        wait_play("tie");
        guess = target; submit = 1'b1; tick();
        end_f = 1'b1; tick(); end_f = 1'b0; submit = 1'b0;
        check("tie_miss_p", int'(miss_p), 1);
        check("tie_no_hit", int'(hit_p), 0);
        tick();
        check("tie_score", int'(score), 1);
        check("tie_lives", int'(lives), 2);

        // remaining lives run out
        miss_round(); check("lives_1", int'(lives), 1);
        miss_round(); check("lives_0", int'(lives), 0);
        check("g2_over", int'(game_over), 1);
        for (int i = 0; i < 5; i++) begin
            tick(); check("over_set_f_low", int'(set_f), 0);
        end

        // game 3: asynchronous reset in the middle of a round
        start = 1'b1; wait_set_f("g3"); start = 1'b0;
        repeat (4) win_round();
        check("g3_score_4", int'(score), 4);
        wait_play("g3");
        #3 rst_n = 1'b0;
        #1;
        check("arst_set_f",        int'(set_f), 0);
        check("arst_set_v",        int'(set_v), 0);
        check("arst_target",       int'(target), 0);
        check("arst_score",        int'(score), 0);
        check("arst_lives",        int'(lives), 3);
        check("arst_round_active", int'(round_active), 0);
        check("arst_game_over",    int'(game_over), 0);
        check("arst_hit_p",        int'(hit_p), 0);
        check("arst_miss_p",       int'(miss_p), 0);
        tick(2); rst_n = 1'b1; tick(3);
        check("post_rst_idle", int'(set_f | round_active), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
